// File: rtl/recharge.sv
// rtl/recharge.sv - balance register fed by recharge keys and billing deductions; option RECHARGE_DEBOUNCE_EN
module recharge #(
    parameter int DB_CYCLES = 2000000,
    parameter int BAL_INIT  = 0,
    parameter int BAL_MAX   = 999,
    parameter int BAL_MIN   = -99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on,
    input  logic        key_add1,
    input  logic        key_add10,
    input  logic        key_clr,
    input  logic        charge_req,
    input  logic [7:0]  charge_amt,
    output logic [11:0] bal,
    output logic        charge_ack,
    output logic        owe,
    output logic        sat
);
    localparam logic signed [13:0] MAX_V  = 14'(BAL_MAX);
    localparam logic signed [13:0] MIN_V  = 14'(BAL_MIN);
    localparam logic [11:0]        INIT_V = 12'(BAL_INIT);

    if (DB_CYCLES < 1 || BAL_MIN > BAL_MAX) begin : g_bad_params
        $error("recharge: DB_CYCLES must be >= 1 and BAL_MIN <= BAL_MAX");
    end

    // key vector order: [0]=add1, [1]=add10, [2]=clr
    logic [2:0] keys, sync1, sync2, press;
    assign keys = {key_clr, key_add10, key_add1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

`ifdef RECHARGE_DEBOUNCE_EN
    // The flip lands on the edge where the count would reach DB_CYCLES-1.
    localparam int FLIP_AT = (DB_CYCLES > 2) ? DB_CYCLES - 2 : 0;
    localparam int CW      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES - 1) : 1;

    logic [CW-1:0] cnt [3];
    logic [2:0]    deb, deb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FLIP_AT)) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press = deb & ~deb_q;
`else
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= sync2;
    end

    assign press = sync2 & ~sync_q;
`endif

    logic               req_q, accept, clr_go, upd, clamp_hi, clamp_lo;
    logic signed [13:0] base, add_sum, sub_amt, sum, bal_next;

    always_comb begin
        accept  = charge_req & ~req_q;
        clr_go  = press[2] & ~on;
        upd     = press[0] | press[1] | clr_go | accept;
        base    = clr_go ? 14'sd0 : {{2{bal[11]}}, bal};
        add_sum = 14'sd0;
        // Clear discards same-cycle adds but still lets a deduction through.
        if (!clr_go) add_sum = (press[0] ? 14'sd1 : 14'sd0) + (press[1] ? 14'sd10 : 14'sd0);
        sub_amt  = accept ? $signed({6'd0, charge_amt}) : 14'sd0;
        sum      = base + add_sum - sub_amt;
        clamp_hi = sum > MAX_V;
        clamp_lo = sum < MIN_V;
        bal_next = clamp_hi ? MAX_V : (clamp_lo ? MIN_V : sum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q      <= 1'b0;
            bal        <= INIT_V;
            charge_ack <= 1'b0;
            owe        <= (BAL_INIT < 0);
            sat        <= 1'b0;
        end else begin
            req_q      <= charge_req;
            charge_ack <= accept;
            if (upd) begin
                bal <= bal_next[11:0];
                owe <= (bal_next < 14'sd0);
                sat <= (sat & ~clr_go) | clamp_hi | clamp_lo;
            end
        end
    end
endmodule
